// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access controller.
// Issues one request per aligned load/store and holds the pipe until ready or timeout.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        Clk,
   input  logic        Clr_n,
   input  logic        MEM_MemRead,
   input  logic        MEM_MemWrite,
   input  logic        MEM_RegWrite,
   input  logic        MEM_MemtoReg,
   input  logic [31:0] MEM_ALUResult,
   input  logic [31:0] MEM_Data2,
   input  logic [4:0]  MEM_RegDstData,
   input  logic        DM_Ready,
   input  logic [31:0] DM_RData,
   output logic        DM_Req,
   output logic        DM_We,
   output logic [31:0] DM_Addr,
   output logic [31:0] DM_WData,
   output logic        Stall,
   output logic        WB_Valid,
   output logic        WB_RegWrite,
   output logic        WB_MemtoReg,
   output logic [31:0] WB_ALUResult,
   output logic [31:0] WB_ReadData,
   output logic [4:0]  WB_RegDstData,
   output logic        MisalignErr,
   output logic        TimeoutErr
);

   localparam int unsigned CLOG = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned CW = (CLOG > 8) ? CLOG : 8;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        wb_valid_q, wb_valid_d;
   logic        wb_rw_q, wb_rw_d;
   logic        wb_m2r_q, wb_m2r_d;
   logic [31:0] wb_alu_q, wb_alu_d;
   logic [31:0] wb_rdata_q, wb_rdata_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic        mis_q, mis_d;
   logic        tmo_q, tmo_d;
   logic        access;
   logic        aligned;

   assign access  = MEM_MemRead | MEM_MemWrite;
   assign aligned = (MEM_ALUResult[1:0] == 2'b00);
   assign Stall   = ((state_q == S_IDLE) && access && aligned) ||
                    (state_q == S_WAIT);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wb_valid_d = 1'b0;
      wb_rw_d    = wb_rw_q;
      wb_m2r_d   = wb_m2r_q;
      wb_alu_d   = wb_alu_q;
      wb_rdata_d = wb_rdata_q;
      wb_rd_d    = wb_rd_q;
      mis_d      = 1'b0;
      tmo_d      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            wb_rw_d  = MEM_RegWrite;
            wb_m2r_d = MEM_MemtoReg;
            wb_alu_d = MEM_ALUResult;
            wb_rd_d  = MEM_RegDstData;
            if (access && aligned) begin
               state_d = S_WAIT;
               cnt_d   = '0;
               req_d   = 1'b1;
               we_d    = MEM_MemWrite;
               addr_d  = MEM_ALUResult;
               wdata_d = MEM_Data2;
            end else begin
               wb_valid_d = 1'b1;
               if (access) begin
                  wb_rw_d = 1'b0;
                  mis_d   = 1'b1;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (DM_Ready) begin
               if (!we_q) wb_rdata_d = DM_RData;
               req_d      = 1'b0;
               state_d    = S_DONE;
               wb_valid_d = 1'b1;
            end else if (cnt_q >= LAST) begin
               req_d      = 1'b0;
               state_d    = S_DONE;
               wb_valid_d = 1'b1;
               wb_rw_d    = 1'b0;
               tmo_d      = 1'b1;
            end
         end
         // Upstream still holds this instruction; do not resample it.
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Clr_n) begin
      if (!Clr_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wb_valid_q <= 1'b0;
         wb_rw_q    <= 1'b0;
         wb_m2r_q   <= 1'b0;
         wb_alu_q   <= '0;
         wb_rdata_q <= '0;
         wb_rd_q    <= '0;
         mis_q      <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wb_valid_q <= wb_valid_d;
         wb_rw_q    <= wb_rw_d;
         wb_m2r_q   <= wb_m2r_d;
         wb_alu_q   <= wb_alu_d;
         wb_rdata_q <= wb_rdata_d;
         wb_rd_q    <= wb_rd_d;
         mis_q      <= mis_d;
         tmo_q      <= tmo_d;
      end
   end

   assign DM_Req        = req_q;
   assign DM_We         = we_q;
   assign DM_Addr       = addr_q;
   assign DM_WData      = wdata_q;
   assign WB_Valid      = wb_valid_q;
   assign WB_RegWrite   = wb_rw_q;
   assign WB_MemtoReg   = wb_m2r_q;
   assign WB_ALUResult  = wb_alu_q;
   assign WB_ReadData   = wb_rdata_q;
   assign WB_RegDstData = wb_rd_q;
   assign MisalignErr   = mis_q;
   assign TimeoutErr    = tmo_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: transaction-level checks of mem_access_ctrl
// against an instruction-by-instruction reference model.
module tb_mem_access_ctrl;

   localparam int T = 4;

   logic        Clk = 1'b0;
   logic        Clr_n = 1'b0;
   logic        MEM_MemRead = 1'b0;
   logic        MEM_MemWrite = 1'b0;
   logic        MEM_RegWrite = 1'b0;
   logic        MEM_MemtoReg = 1'b0;
   logic [31:0] MEM_ALUResult = '0;
   logic [31:0] MEM_Data2 = '0;
   logic [4:0]  MEM_RegDstData = '0;
   logic        DM_Ready = 1'b0;
   logic [31:0] DM_RData = '0;
   logic        DM_Req, DM_We, Stall, WB_Valid;
   logic [31:0] DM_Addr, DM_WData;
   logic        WB_RegWrite, WB_MemtoReg;
   logic [31:0] WB_ALUResult, WB_ReadData;
   logic [4:0]  WB_RegDstData;
   logic        MisalignErr, TimeoutErr;

   always #5 Clk = ~Clk;

   mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
      .Clk(Clk), .Clr_n(Clr_n),
      .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
      .MEM_RegWrite(MEM_RegWrite), .MEM_MemtoReg(MEM_MemtoReg),
      .MEM_ALUResult(MEM_ALUResult), .MEM_Data2(MEM_Data2),
      .MEM_RegDstData(MEM_RegDstData),
      .DM_Ready(DM_Ready), .DM_RData(DM_RData),
      .DM_Req(DM_Req), .DM_We(DM_We), .DM_Addr(DM_Addr),
      .DM_WData(DM_WData), .Stall(Stall), .WB_Valid(WB_Valid),
      .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg),
      .WB_ALUResult(WB_ALUResult), .WB_ReadData(WB_ReadData),
      .WB_RegDstData(WB_RegDstData),
      .MisalignErr(MisalignErr), .TimeoutErr(TimeoutErr)
   );

   typedef struct packed {
      logic        mr, mw, rw, m2r;
      logic [31:0] alu, d2;
      logic [4:0]  rd;
   } instr_t;

   int errs = 0;
   int checks = 0;

   // Expected WB for the cycle after a single-cycle instruction.
   logic        p_valid = 1'b0, p_mis = 1'b0, p_rw = 1'b0, p_m2r = 1'b0;
   logic [31:0] p_alu = '0;
   logic [4:0]  p_rd = '0;
   logic [31:0] rd_model = '0;

   function automatic instr_t mk(input logic mr, input logic mw, input logic rw,
                                 input logic m2r, input logic [31:0] alu,
                                 input logic [31:0] d2, input logic [4:0] rd);
      instr_t i;
      i.mr = mr; i.mw = mw; i.rw = rw; i.m2r = m2r;
      i.alu = alu; i.d2 = d2; i.rd = rd;
      return i;
   endfunction

   // One instruction held upstream until Stall drops; lat = WAIT cycles to ready.
   task automatic step(input instr_t in, input int lat, input logic [31:0] rdata);
      logic acc, mis, mem, tmo;
      logic [127:0] g, e;
      int nw;
      acc = in.mr | in.mw;
      mis = acc && (in.alu[1:0] != 2'b00);
      mem = acc && !mis;
      tmo = (lat > T);
      nw  = tmo ? T : lat;
      MEM_MemRead = in.mr; MEM_MemWrite = in.mw;
      MEM_RegWrite = in.rw; MEM_MemtoReg = in.m2r;
      MEM_ALUResult = in.alu; MEM_Data2 = in.d2; MEM_RegDstData = in.rd;
      DM_Ready = 1'($urandom); DM_RData = $urandom;
      @(negedge Clk);
      g = 128'({WB_Valid, MisalignErr, TimeoutErr});
      e = 128'({p_valid, p_mis, 1'b0});
      checks++;
      if (g !== e) begin
         errs++; $display("FAIL wb_flags got=%h exp=%h", g, e);
      end
      if (p_valid) begin
         g = 128'({WB_RegWrite, WB_MemtoReg, WB_RegDstData, WB_ALUResult, WB_ReadData});
         e = 128'({p_rw, p_m2r, p_rd, p_alu, rd_model});
         checks++;
         if (g !== e) begin
            errs++; $display("FAIL wb_fields got=%h exp=%h", g, e);
         end
      end
      g = 128'({Stall, DM_Req});
      e = 128'({mem, 1'b0});
      checks++;
      if (g !== e) begin
         errs++; $display("FAIL issue_stall got=%h exp=%h", g, e);
      end
      @(posedge Clk); #1;
      if (mem) begin
         for (int w = 1; w <= nw; w++) begin
            DM_Ready = (w == lat);
            DM_RData = (w == lat) ? rdata : $urandom;
            @(negedge Clk);
            g = 128'({Stall, DM_Req, DM_We, DM_Addr, DM_WData, WB_Valid});
            e = 128'({1'b1, 1'b1, in.mw, in.alu, in.d2, 1'b0});
            checks++;
            if (g !== e) begin
               errs++; $display("FAIL wait_req got=%h exp=%h", g, e);
            end
            @(posedge Clk); #1;
         end
         DM_Ready = 1'($urandom); DM_RData = $urandom;
         if (!tmo && !in.mw) rd_model = rdata;
         @(negedge Clk);
         g = 128'({WB_Valid, Stall, DM_Req, MisalignErr, TimeoutErr});
         e = 128'({1'b1, 1'b0, 1'b0, 1'b0, tmo});
         checks++;
         if (g !== e) begin
            errs++; $display("FAIL done_flags got=%h exp=%h", g, e);
         end
         g = 128'({WB_RegWrite, WB_MemtoReg, WB_RegDstData, WB_ALUResult, WB_ReadData});
         e = 128'({in.rw & !tmo, in.m2r, in.rd, in.alu, rd_model});
         checks++;
         if (g !== e) begin
            errs++; $display("FAIL done_fields got=%h exp=%h", g, e);
         end
         @(posedge Clk); #1;
         p_valid = 1'b0; p_mis = 1'b0;
      end else begin
         p_valid = 1'b1; p_mis = mis;
         p_rw = in.rw & !mis; p_m2r = in.m2r;
         p_rd = in.rd; p_alu = in.alu;
      end
   endtask

   task automatic test_reset();
      logic [127:0] g;
      Clr_n = 1'b0;
      #3;
      g = 128'({DM_Req, DM_We, DM_Addr, DM_WData, Stall, WB_Valid, WB_RegWrite,
                WB_MemtoReg, WB_RegDstData, MisalignErr, TimeoutErr});
      checks++;
      if (g !== '0) begin
         errs++; $display("FAIL reset_ctl got=%h exp=0", g);
      end
      g = 128'({WB_ALUResult, WB_ReadData});
      checks++;
      if (g !== '0) begin
         errs++; $display("FAIL reset_wb got=%h exp=0", g);
      end
      @(posedge Clk); @(posedge Clk); #1;
      Clr_n = 1'b1;
      rd_model = '0; p_valid = 1'b0; p_mis = 1'b0;
   endtask

   task automatic test_directed();
      step(mk(1, 0, 1, 1, 32'h10, 32'h0, 5'd3), 3, 32'hDEADBEEF);
      step(mk(0, 1, 0, 0, 32'h20, 32'h1234, 5'd0), 1, 32'h0);
      step(mk(0, 0, 1, 0, 32'd7, 32'h0, 5'd5), 1, 32'h0);
      step(mk(1, 0, 1, 1, 32'h13, 32'h0, 5'd9), 1, 32'h0);
      step(mk(1, 0, 1, 1, 32'h40, 32'h0, 5'd4), 100, 32'h0);
      step(mk(1, 0, 1, 1, 32'h44, 32'h0, 5'd6), T, 32'hCAFEF00D);
      step(mk(1, 1, 1, 0, 32'h48, 32'h55AA, 5'd7), 2, 32'h0BADBAD0);
   endtask

   task automatic test_random();
      instr_t in;
      int k;
      for (int n = 0; n < 300; n++) begin
         k = $urandom_range(0, 3);
         in = mk(k == 1 || k == 3, k == 2 || k == 3, 1'($urandom),
                 1'($urandom), $urandom, $urandom, 5'($urandom));
         if ($urandom_range(0, 3) != 0) in.alu[1:0] = 2'b00;
         step(in, $urandom_range(1, T + 2), $urandom);
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 8; n++)
         step(mk(0, 0, 1, 0, $urandom, $urandom, 5'($urandom)), 1, 32'h0);
   endtask

   task automatic test_reset_mid_wait();
      logic [127:0] g;
      step(mk(0, 0, 0, 0, 32'h0, 32'h0, 5'd0), 1, 32'h0);
      MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0; MEM_RegWrite = 1'b1;
      MEM_ALUResult = 32'h80; DM_Ready = 1'b0;
      @(posedge Clk); #1;
      @(negedge Clk);
      checks++;
      if (DM_Req !== 1'b1) begin
         errs++; $display("FAIL rst_wait_req got=%b exp=1", DM_Req);
      end
      #2 Clr_n = 1'b0;
      #1;
      g = 128'({DM_Req, DM_We, DM_Addr, WB_Valid, MisalignErr, TimeoutErr});
      checks++;
      if (g !== '0) begin
         errs++; $display("FAIL rst_async got=%h exp=0", g);
      end
      MEM_MemRead = 1'b0; MEM_RegWrite = 1'b0;
      DM_Ready = 1'b1; DM_RData = 32'h77777777;
      @(posedge Clk); @(posedge Clk); #1;
      Clr_n = 1'b1;
      rd_model = '0; p_valid = 1'b0; p_mis = 1'b0;
      step(mk(0, 0, 0, 0, 32'h0, 32'h0, 5'd0), 1, 32'h0);
      step(mk(0, 0, 1, 0, 32'h3, 32'h0, 5'd2), 1, 32'h0);
      step(mk(0, 1, 0, 0, 32'hC, 32'h9, 5'd0), 100, 32'h0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_mid_wait();
      step(mk(0, 0, 0, 0, 32'h0, 32'h0, 5'd0), 1, 32'h0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 64, max cycles waited for DM_Ready before abort.
REQ-002 SHALL have ports (name direction width meaning):
- Clk  in  1  single clock; all state changes on posedge.
- Clr_n  in  1  reset, asynchronous, active-low.
- MEM_MemRead  in  1  load in MEM stage.
- MEM_MemWrite  in  1  store in MEM stage.
- MEM_RegWrite  in  1  instruction writes register file.
- MEM_MemtoReg  in  1  writeback selects memory data.
- MEM_ALUResult  in  32  byte address / ALU result.
- MEM_Data2  in  32  store data.
- MEM_RegDstData  in  5  destination register.
- DM_Ready  in  1  memory completes current request.
- DM_RData  in  32  read data, valid with DM_Ready.
- DM_Req  out  1  memory request.
- DM_We  out  1  1 = write, 0 = read.
- DM_Addr  out  32  request address.
- DM_WData  out  32  write data.
- Stall  out  1  drives Ld low on EX_MEM and upstream pipeline registers.
- WB_Valid  out  1  WB_* fields valid this cycle.
- WB_RegWrite, WB_MemtoReg  out  1 each  forwarded controls.
- WB_ALUResult, WB_ReadData  out  32 each  ALU result, loaded data.
- WB_RegDstData  out  5  destination register.
- MisalignErr, TimeoutErr  out  1 each  one-cycle error pulses.

Function
REQ-003 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-004 Access = MEM_MemRead | MEM_MemWrite sampled in IDLE; both high SHALL be treated as write.
REQ-005 Stall SHALL be combinational: 1 when (IDLE and access and MEM_ALUResult[1:0]==0) or state==WAIT; 0 otherwise, including DONE.
REQ-006 IDLE, aligned access: SHALL capture address, data, and direction into DM_Addr/DM_WData/DM_We, enter WAIT; DM_Req = 1 from the next cycle.
REQ-007 WAIT: DM_Req, DM_We, DM_Addr, DM_WData SHALL stay stable until the cycle DM_Ready = 1 is sampled.
REQ-008 WAIT with DM_Ready = 1: SHALL capture DM_RData into WB_ReadData for reads (writes keep WB_ReadData unchanged), drop DM_Req next cycle, enter DONE.
REQ-009 WAIT cycle counter SHALL be 8 bits minimum and clear on WAIT entry; on reaching TIMEOUT_CYCLES without DM_Ready, SHALL enter DONE with TimeoutErr = 1 and WB_RegWrite = 0.
REQ-010 DONE: WB_Valid = 1 for exactly one cycle with captured WB_* fields; next state IDLE unconditionally; inputs SHALL NOT be resampled in DONE (same instruction still held upstream).
REQ-011 IDLE, no access: WB_* SHALL be registered copies of inputs with WB_Valid = 1 on the next cycle (latency 1); no request.
REQ-012 IDLE, access with MEM_ALUResult[1:0] != 0: no request, no stall; next cycle WB_Valid = 1, WB_RegWrite = 0, MisalignErr = 1 for one cycle.
REQ-013 DM_Ready while not in WAIT SHALL be ignored.
REQ-014 Memory-op latency: Stall asserted for (ready cycle − issue cycle + 1) cycles; WB_Valid exactly one cycle after DM_Ready sampled.

Reset
REQ-015 Clr_n = 0 SHALL immediately force state IDLE, counter 0, and all registered outputs to 0 (DM_Req, DM_We, DM_Addr, DM_WData, WB_*, error flags), regardless of clock.
REQ-016 Reset during WAIT SHALL drop DM_Req asynchronously; the aborted access SHALL produce no WB_Valid after release.
REQ-017 First sampling after Clr_n deasserts SHALL occur on the next posedge in IDLE.

Verification
REQ-018 Load addr 0x10, DM_Ready 3 cycles after DM_Req, RData 0xDEADBEEF -> Stall 4 cycles, WB_Valid 1 cycle with WB_ReadData 0xDEADBEEF, WB_MemtoReg 1.
REQ-019 Store addr 0x20 data 0x1234, Ready same cycle as DM_Req -> DM_We 1, DM_WData 0x1234 stable, Stall 2 cycles, WB_Valid once.
REQ-020 ALU op, RegDst 5, ALUResult 7, no mem -> next cycle WB_Valid 1, WB_ALUResult 7, WB_RegDstData 5, Stall never 1.
REQ-021 Load addr 0x13 -> no DM_Req, MisalignErr 1 cycle, WB_RegWrite 0, Stall 0.
REQ-022 TIMEOUT_CYCLES 4, DM_Ready held 0 -> TimeoutErr after 4 WAIT cycles, WB_RegWrite 0, return IDLE; Clr_n low mid-WAIT -> DM_Req 0 immediately, no WB_Valid.
